// File: rtl/lcd_host_agent.sv
// System-side partner for the LCD controller: image ROM, command script issue and result capture.
// Optional HOST_TIMEOUT_EN adds a run watchdog and a sticky timeout output.
module lcd_host_agent #(
   parameter int SCRIPT_DEPTH   = 32,
   parameter int CMD_GAP        = 1,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int AW            = $clog2(SCRIPT_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          img_we,
   input  logic [5:0]    img_addr,
   input  logic [7:0]    img_data,
   input  logic          scr_we,
   input  logic [AW-1:0] scr_addr,
   input  logic [2:0]    scr_data,
   input  logic [AW:0]   scr_len,
   input  logic          start,
   input  logic          IROM_EN,
   input  logic [5:0]    IROM_A,
   output logic [7:0]    IROM_Q,
   output logic [2:0]    cmd,
   output logic          cmd_valid,
   input  logic          busy,
   input  logic          done,
   input  logic          IRB_RW,
   input  logic [5:0]    IRB_A,
   input  logic [7:0]    IRB_D,
   input  logic [5:0]    rb_addr,
   output logic [7:0]    rb_data,
`ifdef HOST_TIMEOUT_EN
   output logic          timeout,
`endif
   output logic          running,
   output logic          finish,
   output logic [15:0]   checksum,
   output logic [6:0]    wr_count,
   output logic          err
);

   // state   | meaning
   // S_IDLE  | waiting for start
   // S_WAIT  | waiting for busy low before next command
   // S_ISSUE | cmd_valid high for one cycle
   // S_GAP   | CMD_GAP idle cycles after a command
   // S_DONE  | write command issued, waiting for done
   // S_FIN   | one-cycle finish pulse, error latched
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_GAP, S_DONE, S_FIN} state_t;

   logic [7:0] rom    [64];
   logic [2:0] script [SCRIPT_DEPTH];
   logic [7:0] res    [64];

   state_t      state, state_nxt;
   logic [AW:0] idx, idx_nxt, len, len_nxt;
   logic [3:0]  gap_cnt, gap_nxt;
   logic [2:0]  cmd_nxt, issue_code;
   logic        cmd_valid_nxt, running_nxt, finish_nxt, err_nxt, clr_acc;
   logic        irb_wr;
   logic [6:0]  wr_count_nxt;

   always_ff @(posedge clk) begin
      if (img_we && !running) rom[img_addr] <= img_data;
      if (scr_we && !running) script[scr_addr] <= scr_data;
      if (irb_wr) res[IRB_A] <= IRB_D;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         IROM_Q <= 8'd0;
      else if (!IROM_EN) IROM_Q <= rom[IROM_A];
   end

   assign rb_data = res[rb_addr];
   assign irb_wr  = !IRB_RW && running;

   // the write landing on the same edge as finish is still counted before err is judged
   always_comb begin
      wr_count_nxt = wr_count;
      if (irb_wr && wr_count != 7'd127) wr_count_nxt = wr_count + 7'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksum <= 16'd0;
         wr_count <= 7'd0;
      end else if (clr_acc) begin
         checksum <= 16'd0;
         wr_count <= 7'd0;
      end else if (irb_wr) begin
         checksum <= checksum + {8'h00, IRB_D};
         wr_count <= wr_count_nxt;
      end
   end

   assign issue_code = (idx >= len) ? 3'd0 : script[idx[AW-1:0]];

`ifdef HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic          timeout_nxt, tmo_hit;
   assign tmo_hit = running && (tmo_cnt == '0) && (state != S_FIN);
`endif

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      len_nxt       = len;
      gap_nxt       = gap_cnt;
      cmd_nxt       = cmd;
      cmd_valid_nxt = 1'b0;
      running_nxt   = running;
      finish_nxt    = 1'b0;
      err_nxt       = err;
      clr_acc       = 1'b0;
`ifdef HOST_TIMEOUT_EN
      timeout_nxt   = timeout;
      tmo_nxt       = tmo_cnt;
      if (running && tmo_cnt != '0) tmo_nxt = tmo_cnt - 1'b1;
`endif
      case (state)
         S_IDLE: if (start) begin
            len_nxt     = scr_len;
            idx_nxt     = '0;
            err_nxt     = 1'b0;
            running_nxt = 1'b1;
            clr_acc     = 1'b1;
            state_nxt   = S_WAIT;
`ifdef HOST_TIMEOUT_EN
            timeout_nxt = 1'b0;
            tmo_nxt     = TW'(TIMEOUT_CYCLES - 1);
`endif
         end
         S_WAIT: if (!busy) begin
            cmd_nxt       = issue_code;
            cmd_valid_nxt = 1'b1;
            state_nxt     = S_ISSUE;
         end
         S_ISSUE: begin
            if (cmd == 3'd0) begin
               state_nxt = S_DONE;
            end else begin
               idx_nxt   = idx + 1'b1;
               gap_nxt   = 4'(CMD_GAP - 1);
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == 4'd0) state_nxt = S_WAIT;
            else                 gap_nxt   = gap_cnt - 4'd1;
         end
         S_DONE: if (done) begin
            finish_nxt  = 1'b1;
            running_nxt = 1'b0;
            err_nxt     = (wr_count_nxt != 7'd64);
            state_nxt   = S_FIN;
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
`ifdef HOST_TIMEOUT_EN
      if (tmo_hit) begin
         cmd_valid_nxt = 1'b0;
         finish_nxt    = 1'b1;
         running_nxt   = 1'b0;
         err_nxt       = 1'b1;
         timeout_nxt   = 1'b1;
         state_nxt     = S_FIN;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         len       <= '0;
         gap_cnt   <= 4'd0;
         cmd       <= 3'd0;
         cmd_valid <= 1'b0;
         running   <= 1'b0;
         finish    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         len       <= len_nxt;
         gap_cnt   <= gap_nxt;
         cmd       <= cmd_nxt;
         cmd_valid <= cmd_valid_nxt;
         running   <= running_nxt;
         finish    <= finish_nxt;
         err       <= err_nxt;
      end
   end

`ifdef HOST_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
         timeout <= 1'b0;
      end else begin
         tmo_cnt <= tmo_nxt;
         timeout <= timeout_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_lcd_host_agent.sv
// Bench for lcd_host_agent: IROM vector table, command scoreboard, controller-side write/done emulation.
module tb_lcd_host_agent;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       img_we = 1'b0;
   logic [5:0] img_addr = '0;
   logic [7:0] img_data = '0;
   logic       scr_we = 1'b0;
   logic [4:0] scr_addr = '0;
   logic [2:0] scr_data = '0;
   logic [5:0] scr_len = '0;
   logic       start = 1'b0;
   logic       IROM_EN = 1'b1;
   logic [5:0] IROM_A = '0;
   logic [7:0] IROM_Q;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       busy = 1'b0;
   logic       done = 1'b0;
   logic       IRB_RW = 1'b1;
   logic [5:0] IRB_A = '0;
   logic [7:0] IRB_D = '0;
   logic [5:0] rb_addr = '0;
   logic [7:0] rb_data;
   logic       running, finish, err;
   logic [15:0] checksum;
   logic [6:0]  wr_count;

   lcd_host_agent #(.SCRIPT_DEPTH(32), .CMD_GAP(3), .TIMEOUT_CYCLES(4096)) dut (
      .clk(clk), .reset(reset),
      .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
      .scr_we(scr_we), .scr_addr(scr_addr), .scr_data(scr_data), .scr_len(scr_len),
      .start(start),
      .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
      .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D),
      .rb_addr(rb_addr), .rb_data(rb_data),
      .running(running), .finish(finish), .checksum(checksum),
      .wr_count(wr_count), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   int fin_cnt = 0;
   logic [2:0] exp_q[$];
   logic [7:0] exp_res[64];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // busy model: goes high for a few cycles after every command, plus a manual hold
   logic busy_en = 1'b0;
   logic busy_hold = 1'b0;
   int   busy_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (busy_en && cmd_valid) busy_cnt = 5;
      else if (busy_cnt != 0)   busy_cnt--;
      busy = busy_hold || (busy_cnt != 0);
   end

   // command monitor: scoreboard pop, pulse width, gap and busy checks
   logic busy_prev = 1'b0;
   logic cv_prev = 1'b0;
   logic have_prev = 1'b0;
   int   low_cnt = 0;
   always @(negedge clk) begin
      if (reset) begin
         have_prev = 1'b0;
         low_cnt   = 0;
      end else begin
         if (cmd_valid) begin
            pulses++;
            if (exp_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
            else                   check("cmd_code", cmd, exp_q.pop_front());
            check("cmd_busy_low", busy_prev, 1'b0);
            check("cmd_valid_width", cv_prev, 1'b0);
            if (have_prev) check("cmd_gap_ge3", low_cnt >= 3, 1'b1);
            have_prev = 1'b1;
            low_cnt   = 0;
         end else begin
            low_cnt++;
         end
         if (finish) fin_cnt++;
      end
      busy_prev = busy;
      cv_prev   = cmd_valid;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_pulses(input int n);
      int k = 0;
      while (pulses < n && k < 300) begin
         tick();
         k++;
      end
      check("pulse_wait", pulses >= n, 1'b1);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic ctrl_writes(input int n, input int mult, output int sum);
      sum = 0;
      for (int i = 0; i < n; i++) begin
         IRB_RW = 1'b0;
         IRB_A  = 6'(i);
         IRB_D  = 8'(i * mult);
         exp_res[i] = 8'(i * mult);
         sum += i * mult % 256;
         tick();
      end
      IRB_RW = 1'b1;
   endtask

   task automatic finish_run(input logic [6:0] exp_wc, input logic exp_err, input int sum);
      int f0 = fin_cnt;
      int k = 0;
      done = 1'b1;
      tick();
      done = 1'b0;
      while (fin_cnt == f0 && k < 50) begin
         tick();
         k++;
      end
      check("finish_seen", fin_cnt != f0, 1'b1);
      check("running_after", running, 1'b0);
      check("wr_count", wr_count, exp_wc);
      check("err", err, exp_err);
      check("checksum", checksum, 32'(sum % 65536));
      repeat (4) tick();
      check("single_finish", fin_cnt - f0, 32'd1);
   endtask

   typedef struct {
      logic       en;
      logic [5:0] a;
      logic [7:0] q;
   } irom_vec_t;

   initial begin
      irom_vec_t tv[8];
      int sum;
      int p0;
      int f0;
      tv[0] = '{1'b0, 6'd5,  8'd5};
      tv[1] = '{1'b0, 6'd6,  8'd6};
      tv[2] = '{1'b1, 6'd20, 8'd6};
      tv[3] = '{1'b1, 6'd5,  8'd6};
      tv[4] = '{1'b0, 6'd63, 8'd63};
      tv[5] = '{1'b0, 6'd0,  8'd0};
      tv[6] = '{1'b1, 6'd40, 8'd0};
      tv[7] = '{1'b0, 6'd33, 8'd33};

      repeat (3) tick();
      check("rst_IROM_Q", IROM_Q, 8'd0);
      check("rst_cmd", cmd, 3'd0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_running", running, 1'b0);
      check("rst_finish", finish, 1'b0);
      check("rst_checksum", checksum, 16'd0);
      check("rst_wr_count", wr_count, 7'd0);
      check("rst_err", err, 1'b0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 64; i++) begin
         img_we = 1'b1; img_addr = 6'(i); img_data = 8'(i);
         tick();
      end
      img_we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         scr_we   = 1'b1;
         scr_addr = 5'(i);
         scr_data = (i == 0) ? 3'd4 : (i == 1) ? 3'd2 : (i == 2) ? 3'd5 : (i == 3) ? 3'd0 : 3'd7;
         tick();
      end
      scr_we = 1'b0;

      // write-only run; stray start/done/preload writes while running must be ignored
      scr_len = 6'd0;
      busy_hold = 1'b1;
      exp_q.push_back(3'd0);
      p0 = pulses;
      f0 = fin_cnt;
      do_start();
      check("running_on_start", running, 1'b1);
      done = 1'b1; tick(); done = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      scr_we = 1'b1; scr_addr = 5'd0; scr_data = 3'd7; tick(); scr_we = 1'b0;
      img_we = 1'b1; img_addr = 6'd5; img_data = 8'hFF; tick(); img_we = 1'b0;
      repeat (3) tick();
      check("no_cmd_while_busy", pulses - p0, 32'd0);
      check("early_done_ignored", fin_cnt - f0, 32'd0);
      busy_hold = 1'b0;
      wait_pulses(p0 + 1);
      ctrl_writes(64, 1, sum);
      check("sum_2016", sum, 32'd2016);
      finish_run(7'd64, 1'b0, sum);
      for (int i = 0; i < 64; i++) begin
         rb_addr = 6'(i);
         #1;
         check("rb_data", rb_data, exp_res[i]);
      end

      for (int i = 0; i < 8; i++) begin
         IROM_EN = tv[i].en;
         IROM_A  = tv[i].a;
         @(posedge clk);
         #1;
         check("irom_q", IROM_Q, tv[i].q);
      end
      IROM_EN = 1'b1;
      tick();

      // script {4,2,5,0}: trailing 7 is never issued
      busy_en = 1'b1;
      scr_len = 6'd5;
      exp_q.push_back(3'd4); exp_q.push_back(3'd2);
      exp_q.push_back(3'd5); exp_q.push_back(3'd0);
      p0 = pulses;
      do_start();
      wait_pulses(p0 + 4);
      ctrl_writes(64, 3, sum);
      finish_run(7'd64, 1'b0, sum);
      check("four_pulses", pulses - p0, 32'd4);
      check("queue_empty_b", exp_q.size(), 32'd0);

      // script {1,1,3} then auto-appended 0; controller short by one write
      for (int i = 0; i < 4; i++) begin
         scr_we = 1'b1; scr_addr = 5'(i);
         scr_data = (i == 2) ? 3'd3 : (i == 3) ? 3'd6 : 3'd1;
         tick();
      end
      scr_we = 1'b0;
      scr_len = 6'd3;
      exp_q.push_back(3'd1); exp_q.push_back(3'd1);
      exp_q.push_back(3'd3); exp_q.push_back(3'd0);
      p0 = pulses;
      do_start();
      wait_pulses(p0 + 4);
      ctrl_writes(63, 5, sum);
      finish_run(7'd63, 1'b1, sum);
      check("queue_empty_c", exp_q.size(), 32'd0);

      // reset while in S_GAP
      busy_hold = 1'b1;
      exp_q.push_back(3'd1);
      p0 = pulses;
      f0 = fin_cnt;
      do_start();
      ctrl_writes(3, 9, sum);
      check("pre_reset_wr_count", wr_count, 7'd3);
      busy_hold = 1'b0;
      wait_pulses(p0 + 1);
      tick();
      reset = 1'b1;
      #1;
      check("gap_rst_cmd", cmd, 3'd0);
      check("gap_rst_cmd_valid", cmd_valid, 1'b0);
      check("gap_rst_running", running, 1'b0);
      check("gap_rst_checksum", checksum, 16'd0);
      check("gap_rst_wr_count", wr_count, 7'd0);
      check("gap_rst_err", err, 1'b0);
      check("gap_rst_IROM_Q", IROM_Q, 8'd0);
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b0;
      repeat (6) tick();
      check("no_finish_after_reset", fin_cnt - f0, 32'd0);

      scr_len = 6'd0;
      exp_q.push_back(3'd0);
      p0 = pulses;
      do_start();
      wait_pulses(p0 + 1);
      ctrl_writes(64, 7, sum);
      finish_run(7'd64, 1'b0, sum);

      IROM_EN = 1'b0; IROM_A = 6'd5;
      @(posedge clk); #1;
      check("rom5_intact", IROM_Q, 8'd5);
      IROM_A = 6'd10;
      @(posedge clk); #1;
      check("rom10_intact", IROM_Q, 8'd10);
      IROM_EN = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench watchdog expired");
   end

endmodule

// File: doc/lcd_host_agent.md
Name: lcd_host_agent

Overview:
- Counterpart of the LCD controller: serves the image ROM, issues the command script, and absorbs the result buffer.
- Responds to IROM reads, drives cmd/cmd_valid under the busy handshake, captures IRB writes into a 64x8 result store, and reports checksum and completion.
- Used as the system-side partner in block-level simulation and FPGA bring-up.

Parameters:
- SCRIPT_DEPTH, 32, number of command-script entries; address width clog2(SCRIPT_DEPTH).
- CMD_GAP, 1, idle cycles (cmd_valid=0) inserted after each issued command; legal range 1..15.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- img_we  in  1  image-ROM preload write strobe; ignored while running
- img_addr  in  6  preload address
- img_data  in  8  preload data
- scr_we  in  1  script preload write strobe; ignored while running
- scr_addr  in  clog2(SCRIPT_DEPTH)  script address
- scr_data  in  3  script command code
- scr_len  in  clog2(SCRIPT_DEPTH)+1  number of script entries; latched on start
- start  in  1  one-cycle run request; honoured only in S_IDLE
- IROM_EN  in  1  ROM enable from controller, active-low
- IROM_A  in  6  ROM address from controller
- IROM_Q  out  8  ROM data to controller
- cmd  out  3  command code
- cmd_valid  out  1  command strobe
- busy  in  1  controller busy
- done  in  1  controller done
- IRB_RW  in  1  0 = write
- IRB_A  in  6  result address
- IRB_D  in  8  result data
- rb_addr  in  6  result readback address
- rb_data  out  8  combinational read of result store at rb_addr
- running  out  1  high from start accepted until finish
- finish  out  1  one-cycle pulse at end of run
- checksum  out  16  sum of all captured IRB bytes, mod 2^16
- wr_count  out  7  number of IRB writes captured this run
- err  out  1  sticky; set if wr_count != 64 at finish; cleared on next start

Behaviour:
- Reset values: IROM_Q=0, cmd=0, cmd_valid=0, running=0, finish=0, checksum=0, wr_count=0, err=0, FSM=S_IDLE.
- Reset leaves ROM, script and result memories unchanged.
- Reset mid-run aborts immediately; no finish pulse is produced.
- IROM port: at each posedge with IROM_EN=0, IROM_Q <= rom[IROM_A]. One-cycle read latency. IROM_Q holds its value when IROM_EN=1.
- IRB port: at each posedge with IRB_RW=0 and running=1, res[IRB_A] <= IRB_D, checksum += IRB_D, and wr_count increments, saturating at 127.
- A repeated address is still counted and summed.
- FSM states:
  - S_IDLE: on start, latch scr_len, clear checksum/wr_count/err, set running, clear idx, go to S_WAIT.
  - S_WAIT: when busy=0, go to S_ISSUE.
  - S_ISSUE (one cycle): cmd_valid=1 and cmd=script[idx], or cmd=0 if idx>=len (auto-appended write).
    - If the issued code is 0, go to S_DONE.
    - Otherwise idx++ and go to S_GAP.
  - S_GAP: hold cmd_valid=0 for CMD_GAP cycles, then go to S_WAIT.
  - S_DONE: wait for done=1, then go to S_FIN.
  - S_FIN (one cycle): finish=1, running=0, err=(wr_count!=64), then S_IDLE.
- cmd holds its last value outside S_ISSUE.
- scr_len=0: the auto-appended write is issued immediately, producing a write-only run.
- Script entries after the first 0 code are never issued.
- start while running is ignored. img_we/scr_we while running are ignored.
- done asserted before a write has been issued is ignored.

Optional Feature:
- HOST_TIMEOUT_EN defined:
  - A counter runs while running=1.
  - If it reaches TIMEOUT_CYCLES before S_FIN, the FSM forces S_FIN, err=1, and a timeout output (1 bit, reset 0, sticky until next start) is set.
- HOST_TIMEOUT_EN undefined: no counter and no timeout port; S_DONE waits indefinitely.

Test Plan:
- Preload rom[i]=i, scr_len=0, start -> single cmd=0 issued after busy falls. Capture: res[i]=i, checksum=2016, wr_count=64, err=0, one finish pulse.
- IROM timing: IROM_EN=0, IROM_A=5 then 6 -> IROM_Q=rom[5] on the following cycle, then rom[6]. With IROM_EN=1, IROM_Q is unchanged.
- Script {4,2,5,0} with CMD_GAP=3 -> exactly four cmd_valid pulses, each one cycle, each separated by at least 3 low cycles, issued only when busy=0. Codes appear in order.
- Script {1,1,3} with scr_len=3 -> codes 1,1,3 followed by an auto-appended 0.
- Controller writes only 63 bytes then asserts done -> finish pulse with err=1 and wr_count=63.
- Assert reset while in S_GAP -> all outputs return to reset values in the same cycle and no finish pulse. A new start then runs cleanly, and the ROM contents are still intact.
